addsub16_issue: RTL and testbench
=================================

# addsub16_issue

Issue-and-retire stage wrapped around the 16-bit prefix add/subtract datapath. Buffers add/sub requests in a small FIFO, drives the combinational adder's operand and `cin` pins from the FIFO head, and captures the sum into a registered response with a tag and flags. An optional accumulate mode substitutes the previous result for operand A, so chains of adds and subtracts run at one operation per cycle.

## Interface
- `DEPTH`, default 4: request FIFO entries; power of two, at least 2.
- `TAG_W`, default 4: width of the request/response tag.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  FIFO can accept.
- `req_a`  in  16  operand A.
- `req_b`  in  16  operand B.
- `req_sub`  in  1  1 = A−B, 0 = A+B.
- `req_acc`  in  1  1 = use accumulator in place of `req_a`.
- `req_tag`  in  TAG_W  returned unchanged with the result.
- `acc_clr`  in  1  synchronous accumulator clear.
- `add_a`  out  16  adder operand A.
- `add_b`  out  16  adder operand B, un-inverted; the adder applies the XOR.
- `add_cin`  out  1  adder subtract-select/carry-in.
- `add_s`  in  16  adder sum, combinational from `add_a`/`add_b`/`add_cin`.
- `rsp_valid`  out  1  result held.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_s`  out  16  result.
- `rsp_tag`  out  TAG_W  tag of the result.
- `rsp_zero`  out  1  `rsp_s` == 0.
- `rsp_neg`  out  1  `rsp_s[15]`.

## Operation
- **Push:** `req_valid && req_ready` writes {a, b, sub, acc, tag} at the FIFO tail.
- **Ready:** `req_ready = (count != DEPTH)`. It does not depend on a same-cycle pop.
- **Head drive:** whenever the FIFO is non-empty:
  - `add_a = head.acc ? acc_q : head.a`
  - `add_b = head.b`
  - `add_cin = head.sub`
- **Idle drive:** when the FIFO is empty, `add_a`, `add_b` and `add_cin` are 0.
- **Issue condition:** `issue = !empty && (!rsp_valid || rsp_ready)`.
- **On issue:**
  - Pop the head.
  - Load `rsp_s <= add_s`, `rsp_tag <= head.tag`, and the flags computed from `add_s`.
  - Set `rsp_valid <= 1`.
  - Set `acc_q <= add_s`. This happens for every issued op, accumulate or not.
- **Retire without issue:** `rsp_valid && rsp_ready && !issue` clears `rsp_valid`.
- **Stall:** while `rsp_valid && !rsp_ready`, every `rsp_*` output holds stable.
- **Simultaneous push and pop:** count is unchanged; pointers wrap modulo DEPTH.
- **`acc_clr` priority:** `acc_clr` beats the issue write, so `acc_q <= 0`. An op issuing in the same cycle still uses the old `acc_q` and its response is unaffected.
- **Arithmetic:** all arithmetic is mod 2^16. There is no carry or overflow output. Subtract is A + ~B + 1 as produced by the adder.

## Timing
- **Reset values:** after `rst`, the FIFO is empty and `req_ready` = 1. The following are all 0: `rsp_valid`, `rsp_s`, `rsp_tag`, `rsp_zero`, `rsp_neg`, `acc_q`, `add_a`, `add_b`, `add_cin`.
- **Reset mid-operation:** queued requests and any held response are discarded with no response emitted.
- **Latency:** a request pushed at edge k, with the FIFO empty and the response slot free or draining, issues at edge k+1. `rsp_valid` is high in the cycle after edge k+1.
- **Throughput:** one op per cycle sustained, including back-to-back accumulate ops. `acc_q` updates on the same edge the next head becomes visible.
- **Full FIFO:** `req_ready` = 0. It rises the cycle after a pop.
- **Combinational path:** `add_s` → `rsp_*` registers, through the adder, within one cycle. There is no combinational path from `req_*` or `rsp_ready` to the adder pins.

## Structure
- **Package `addsub16_pkg`:**
  - typedef `addsub_req_t` {a[15:0], b[15:0], sub, acc, tag[TAG_W-1:0]}.
  - constant `DATA_W = 16`.
- **Sub-module `addsub_req_fifo`:**
  - Synchronous FIFO of `addsub_req_t`.
  - Ports: push/pop, `full`, `empty`, `head`.
  - Pointer width `$clog2(DEPTH)` plus a wrap bit.
- **Top level:** issue logic, accumulator, and response register. The adder itself is instantiated by the parent, not inside this block.

## Test plan
- **Basic add:** push a=0x1234, b=0x0101, sub=0, with `rsp_ready` held 1 → `rsp_s`=0x1335, zero=0, neg=0, valid two edges after push.
- **Subtract to zero and negative:** push a=5, b=5, sub=1 → `rsp_s`=0, zero=1. Then push a=3, b=5, sub=1 → `rsp_s`=0xFFFE, neg=1.
- **Accumulate chain:** back-to-back acc ops, +0x0010 (acc=0, a ignored), +0x0020, −0x0005 → responses 0x0010, 0x0030, 0x002B on consecutive cycles. Assert `acc_clr` with the third op → its response is still 0x002B and `acc_q` = 0 afterwards.
- **Backpressure and full:** hold `rsp_ready`=0 and push DEPTH+1 requests → one response is held, DEPTH entries are queued, `req_ready` drops. Release → tags drain in order with no loss and no duplicate.
- **Wrap-around:** push 0xFFFF + 0x0001 → `rsp_s`=0, zero=1. Stream 3×DEPTH requests with random `rsp_ready` → pointer wrap and tag order are correct.
- **Reset mid-stream:** assert `rst` with 3 entries queued and `rsp_valid`=1 → the next cycle shows `rsp_valid`=0, `req_ready`=1, `acc_q`=0, and no stale responses afterwards.

Source files
------------

// File: rtl/addsub16_pkg.sv
// Shared types for the add/sub issue stage: the queued request record and datapath width.
package addsub16_pkg;

   localparam int DATA_W    = 16;
   // Width of the tag field carried through the request FIFO; wider tags are truncated.
   localparam int TAG_MAX_W = 4;

   typedef struct packed {
      logic [DATA_W-1:0]    a;
      logic [DATA_W-1:0]    b;
      logic                 sub;
      logic                 acc;
      logic [TAG_MAX_W-1:0] tag;
   } addsub_req_t;

endpackage

// File: rtl/addsub_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module addsub_req_fifo
   import addsub16_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  addsub_req_t wr_data,
   output logic        full,
   output logic        empty,
   output addsub_req_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   addsub_req_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/addsub16_issue.sv
// Issue/retire stage around an external 16-bit add/sub datapath: queues requests, drives the
// adder from the FIFO head and registers the sum with its tag and flags.
module addsub16_issue
   import addsub16_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = TAG_MAX_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic              req_sub,
   input  logic              req_acc,
   input  logic [TAG_W-1:0]  req_tag,
   input  logic              acc_clr,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   output logic              add_cin,
   input  logic [DATA_W-1:0] add_s,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_s,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_zero,
   output logic              rsp_neg
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready,
   // and a held response (rsp_valid && !rsp_ready) keeps every rsp_* output stable.

   logic        full;
   logic        empty;
   logic        issue;
   addsub_req_t head;
   addsub_req_t wr_req;
   logic [DATA_W-1:0] acc_q;

   assign wr_req = '{a: req_a, b: req_b, sub: req_sub, acc: req_acc, tag: TAG_MAX_W'(req_tag)};

   assign req_ready = !full;
   assign issue     = !empty && (!rsp_valid || rsp_ready);

   addsub_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (req_valid && req_ready),
      .pop     (issue),
      .wr_data (wr_req),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );

   // Adder pins come only from registered state, so no req_* or rsp_ready path reaches the adder.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (!empty) begin
         add_a   = head.acc ? acc_q : head.a;
         add_b   = head.b;
         add_cin = head.sub;
      end
   end

   // A clear wins over the issue write; the issuing op has already consumed the old value.
   always_ff @(posedge clk) begin
      if (rst || acc_clr) acc_q <= '0;
      else if (issue)     acc_q <= add_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_s     <= '0;
         rsp_tag   <= '0;
         rsp_zero  <= 1'b0;
         rsp_neg   <= 1'b0;
      end else if (issue) begin
         rsp_valid <= 1'b1;
         rsp_s     <= add_s;
         rsp_tag   <= TAG_W'(head.tag);
         rsp_zero  <= (add_s == '0);
         rsp_neg   <= add_s[DATA_W-1];
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_addsub16_issue.sv
// Directed bench for addsub16_issue with a behavioural adder standing in for the parent's datapath.
module tb_addsub16_issue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [15:0]       req_a = '0;
   logic [15:0]       req_b = '0;
   logic              req_sub = 1'b0;
   logic              req_acc = 1'b0;
   logic [TAG_W-1:0]  req_tag = '0;
   logic              acc_clr = 1'b0;
   logic [15:0]       add_a;
   logic [15:0]       add_b;
   logic              add_cin;
   logic [15:0]       add_s;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [15:0]       rsp_s;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_zero;
   logic              rsp_neg;

   int total = 0;
   int bad   = 0;
   logic [19:0] exp_q[$];

   always #5 clk = ~clk;

   assign add_s = add_a + (add_cin ? ~add_b : add_b) + 16'(add_cin);

   addsub16_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .req_acc   (req_acc),
      .req_tag   (req_tag),
      .acc_clr   (acc_clr),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_s     (add_s),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_s     (rsp_s),
      .rsp_tag   (rsp_tag),
      .rsp_zero  (rsp_zero),
      .rsp_neg   (rsp_neg)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic sub,
                            input logic acc, input logic [TAG_W-1:0] tag);
      req_a = a; req_b = b; req_sub = sub; req_acc = acc; req_tag = tag;
      req_valid = 1'b1;
   endtask

   task automatic push1(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic acc, input logic [TAG_W-1:0] tag);
      drive_req(a, b, sub, acc, tag);
      step();
      req_valid = 1'b0;
   endtask

   task automatic check_rsp(input string name, input logic [15:0] s, input logic [TAG_W-1:0] tag);
      chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, "_s"},     32'(rsp_s),     32'(s));
      chk({name, "_tag"},   32'(rsp_tag),   32'(tag));
      chk({name, "_zero"},  32'(rsp_zero),  32'(s == 16'h0000));
      chk({name, "_neg"},   32'(rsp_neg),   32'(s[15]));
   endtask

   // Scoreboard: a response offered while rsp_ready is high is consumed at the next edge.
   task automatic monitor();
      logic [19:0] e;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_rsp observed_tag=%0h expected=none", rsp_tag);
         end else begin
            e = exp_q.pop_front();
            chk("sb_tag", 32'(rsp_tag), 32'(e[19:16]));
            chk("sb_s",   32'(rsp_s),   32'(e[15:0]));
         end
      end
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rs;
      int          sent;

      // Reset state
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_s",     32'(rsp_s),     32'd0);
      chk("rst_rsp_tag",   32'(rsp_tag),   32'd0);
      chk("rst_rsp_zero",  32'(rsp_zero),  32'd0);
      chk("rst_rsp_neg",   32'(rsp_neg),   32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_add_a",     32'(add_a),     32'd0);
      chk("rst_add_b",     32'(add_b),     32'd0);
      chk("rst_add_cin",   32'(add_cin),   32'd0);

      // Basic add: valid two edges after the push edge
      push1(16'h1234, 16'h0101, 1'b0, 1'b0, 4'h1);
      chk("basic_head_a",   32'(add_a),     32'h1234);
      chk("basic_head_b",   32'(add_b),     32'h0101);
      chk("basic_head_cin", 32'(add_cin),   32'd0);
      chk("basic_not_yet",  32'(rsp_valid), 32'd0);
      step();
      check_rsp("basic", 16'h1335, 4'h1);
      step();
      chk("basic_retired",  32'(rsp_valid), 32'd0);
      chk("idle_add_a",     32'(add_a),     32'd0);

      // Subtract to zero, then to a negative result
      push1(16'h0005, 16'h0005, 1'b1, 1'b0, 4'h2);
      step();
      check_rsp("sub_zero", 16'h0000, 4'h2);
      push1(16'h0003, 16'h0005, 1'b1, 1'b0, 4'h3);
      chk("sub_head_b",   32'(add_b),   32'h0005);
      chk("sub_head_cin", 32'(add_cin), 32'd1);
      step();
      check_rsp("sub_neg", 16'hFFFE, 4'h3);

      // Wrap-around of the 16-bit sum
      push1(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'h4);
      step();
      check_rsp("wrap", 16'h0000, 4'h4);

      // Accumulate chain at one op per cycle, clear coinciding with the third issue
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      drive_req(16'hAAAA, 16'h0010, 1'b0, 1'b1, 4'h5);
      step();
      drive_req(16'hAAAA, 16'h0020, 1'b0, 1'b1, 4'h6);
      step();
      check_rsp("acc1", 16'h0010, 4'h5);
      drive_req(16'hAAAA, 16'h0005, 1'b1, 1'b1, 4'h7);
      step();
      check_rsp("acc2", 16'h0030, 4'h6);
      req_valid = 1'b0;
      acc_clr = 1'b1;
      step();
      acc_clr = 1'b0;
      check_rsp("acc3", 16'h002B, 4'h7);
      push1(16'h5555, 16'h0000, 1'b0, 1'b1, 4'h8);
      chk("acc_cleared_head", 32'(add_a), 32'd0);
      step();
      check_rsp("acc_probe", 16'h0000, 4'h8);
      step();

      // Backpressure: one held response plus DEPTH queued entries
      rsp_ready = 1'b0;
      for (int t = 8; t < 8 + DEPTH + 1; t++) begin
         chk("bp_ready_before_push", 32'(req_ready), 32'd1);
         push1(16'(t), 16'h0100, 1'b0, 1'b0, TAG_W'(t));
         exp_q.push_back({4'(t), 16'(t) + 16'h0100});
      end
      chk("bp_full_ready", 32'(req_ready), 32'd0);
      chk("bp_held_valid", 32'(rsp_valid), 32'd1);
      chk("bp_held_tag",   32'(rsp_tag),   32'd8);
      drive_req(16'h7777, 16'h0000, 1'b0, 1'b0, 4'hF);
      step();
      req_valid = 1'b0;
      chk("bp_stall_tag",  32'(rsp_tag),   32'd8);
      chk("bp_stall_s",    32'(rsp_s),     32'h0108);
      chk("bp_still_full", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      monitor();
      step();
      chk("bp_ready_after_pop", 32'(req_ready), 32'd1);
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         monitor();
         step();
      end
      chk("bp_drained", 32'(exp_q.size()), 32'd0);
      chk("bp_no_extra", 32'(rsp_valid), 32'd0);

      // Stream 3*DEPTH requests under random backpressure
      sent = 0;
      for (int c = 0; c < 400 && (sent < 3 * DEPTH || exp_q.size() != 0); c++) begin
         if (sent < 3 * DEPTH) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            drive_req(ra, rb, rs, 1'b0, TAG_W'(sent));
            if (req_ready) begin
               exp_q.push_back({4'(sent), rs ? ra - rb : ra + rb});
               sent++;
            end
         end else begin
            req_valid = 1'b0;
         end
         rsp_ready = 1'($urandom_range(0, 1));
         monitor();
         step();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      chk("stream_sent", 32'(sent), 32'(3 * DEPTH));
      chk("stream_left", 32'(exp_q.size()), 32'd0);
      step();

      // Reset with a held response and three queued entries
      rsp_ready = 1'b0;
      for (int t = 1; t <= 4; t++) push1(16'h0077, 16'h0000, 1'b0, 1'b0, TAG_W'(t));
      chk("mid_held_valid", 32'(rsp_valid), 32'd1);
      chk("mid_held_tag",   32'(rsp_tag),   32'd1);
      chk("mid_full_not",   32'(req_ready), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_s",     32'(rsp_s),     32'd0);
      chk("mid_rst_add_a", 32'(add_a),     32'd0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("mid_no_stale", 32'(rsp_valid), 32'd0);
      end
      push1(16'h1234, 16'h0000, 1'b0, 1'b1, 4'h9);
      chk("mid_acc_head", 32'(add_a), 32'd0);
      step();
      check_rsp("mid_acc_probe", 16'h0000, 4'h9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
